// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam int TDM_NCH = 4;
  localparam int TDM_W   = 8;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position tracker: clear, load-to-1 and advance with an explicit wrap at NCH-1.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  parameter int SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          adv,
  output logic [SW-1:0] slot,
  output logic          last_slot
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  assign last_slot = (slot_q == LAST_SLOT);
  assign slot      = slot_q;

  // Wrap is compared against NCH-1 so non power-of-two frames never rely on overflow.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (adv) begin
      slot_d = last_slot ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux_1x4.sv
// TDM receive demultiplexer: locks to frame_sync, steers each slot's word into its
// channel holding register and reports frame completion and framing errors.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  parameter int W   = TDM_W,
  parameter int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_strobe,
  output logic             frame_done,
  output logic             frame_err,
  output logic             locked,
  output logic [SW-1:0]    slot
);

  // Input handshake: a word is consumed on every rising edge where din_valid is high;
  // there is no backpressure, and frame_sync is only looked at alongside din_valid.

  tdm_state_e       state_q, state_d;
  logic [NCH*W-1:0] ch_data_q, ch_data_d;
  logic [NCH-1:0]   ch_strobe_q, ch_strobe_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic             cnt_clr, cnt_load1, cnt_adv, last_slot;
  logic             wr_any;
  logic [SW-1:0]    wr_sel;
  logic [NCH-1:0]   wr_en;

  tdm_slot_counter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .load1     (cnt_load1),
    .adv       (cnt_adv),
    .slot      (slot),
    .last_slot (last_slot)
  );

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load1    = 1'b0;
    cnt_adv      = 1'b0;
    wr_any       = 1'b0;
    wr_sel       = '0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            wr_any    = 1'b1;
            cnt_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 is a short frame; the word still starts a new frame.
            wr_any      = 1'b1;
            cnt_load1   = 1'b1;
            frame_err_d = (slot != '0);
          end else if (slot == '0) begin
            frame_err_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = HUNT;
          end else begin
            wr_any       = 1'b1;
            wr_sel       = slot;
            cnt_adv      = 1'b1;
            frame_done_d = last_slot;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    wr_en     = '0;
    ch_data_d = ch_data_q;
    for (int k = 0; k < NCH; k++) begin
      if (wr_any && (wr_sel == SW'(k))) begin
        wr_en[k]              = 1'b1;
        ch_data_d[k*W +: W]   = din;
      end
    end
  end

  assign ch_strobe_d = wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      ch_data_q    <= '0;
      ch_strobe_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_data_q    <= ch_data_d;
      ch_strobe_q  <= ch_strobe_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_strobe  = ch_strobe_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: a 4x8 and a 3x16 instance share clock and reset, each checked
// by an event scoreboard fed from a frame-level reference model.
module tb_tdm_demux_1x4;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  strobe;
    logic        done;
    logic        err;
    logic        locked;
    logic [1:0]  slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  din0 = '0;
  logic        dv0 = 1'b0, fs0 = 1'b0;
  logic [31:0] ch_data0;
  logic [3:0]  ch_strobe0;
  logic        frame_done0, frame_err0, locked0;
  logic [1:0]  slot0;

  logic [15:0] din1 = '0;
  logic        dv1 = 1'b0, fs1 = 1'b0;
  logic [47:0] ch_data1;
  logic [2:0]  ch_strobe1;
  logic        frame_done1, frame_err1, locked1;
  logic [1:0]  slot1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0, e1;

  bit          m_locked[2];
  int          m_next[2];
  logic [15:0] m_ch[2][4];

  tdm_demux_1x4 dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din0),
    .din_valid  (dv0),
    .frame_sync (fs0),
    .ch_data    (ch_data0),
    .ch_strobe  (ch_strobe0),
    .frame_done (frame_done0),
    .frame_err  (frame_err0),
    .locked     (locked0),
    .slot       (slot0)
  );

  tdm_demux_1x4 #(.NCH(3), .W(16)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din1),
    .din_valid  (dv1),
    .frame_sync (fs1),
    .ch_data    (ch_data1),
    .ch_strobe  (ch_strobe1),
    .frame_done (frame_done1),
    .frame_err  (frame_err1),
    .locked     (locked1),
    .slot       (slot1)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model(input int u);
    m_locked[u] = 1'b0;
    m_next[u]   = 0;
    for (int k = 0; k < 4; k++) m_ch[u][k] = '0;
  endtask

  // Reference model: one accepted-or-ignored word per call, in frame/slot terms.
  task automatic model(input int u, input bit dv, input bit fs, input logic [15:0] d_in);
    int          n;
    int          wr;
    exp_t        e;
    logic [15:0] d;
    n  = (u == 0) ? 4 : 3;
    d  = (u == 0) ? (d_in & 16'h00ff) : d_in;
    wr = -1;
    e.err  = 1'b0;
    e.done = 1'b0;
    if (dv) begin
      if (!m_locked[u]) begin
        if (fs) begin
          wr = 0; m_locked[u] = 1'b1; m_next[u] = 1;
        end
      end else if (fs) begin
        e.err = (m_next[u] != 0);
        wr = 0; m_next[u] = 1;
      end else if (m_next[u] == 0) begin
        e.err = 1'b1; m_locked[u] = 1'b0;
      end else begin
        wr = m_next[u];
        e.done = (m_next[u] == n - 1);
        m_next[u] = (m_next[u] + 1) % n;
      end
    end
    if (wr >= 0) m_ch[u][wr] = d;
    e.data = '0;
    for (int k = 0; k < n; k++) begin
      if (u == 0) e.data[k*8 +: 8] = m_ch[0][k][7:0];
      else        e.data[k*16 +: 16] = m_ch[1][k];
    end
    e.strobe = (wr >= 0) ? 4'(1 << wr) : 4'b0;
    e.locked = m_locked[u];
    e.slot   = 2'(m_next[u]);
    if (wr >= 0 || e.err) begin
      if (u == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  // driver: inputs set on the falling edge, model stepped at the rising edge
  task automatic drive(input int u, input bit dv, input bit fs, input logic [15:0] d);
    @(negedge clk);
    dv0 = 1'b0; dv1 = 1'b0;
    if (u == 0) begin din0 = d[7:0]; dv0 = dv; fs0 = fs; end
    else        begin din1 = d;      dv1 = dv; fs1 = fs; end
    @(posedge clk);
    model(u, dv, fs, d);
    #1;
    dv0 = 1'b0; dv1 = 1'b0;
  endtask

  task automatic gaps(input int u, input int cycles);
    for (int i = 0; i < cycles; i++) drive(u, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && (|ch_strobe0 || frame_done0 || frame_err0)) begin
      if (exp_q0.size() == 0) begin
        check("u0_unexpected_event", {58'h0, frame_done0, frame_err0, ch_strobe0}, 64'h0);
      end else begin
        e0 = exp_q0.pop_front();
        check("u0_ch_data", {32'h0, ch_data0}, e0.data);
        check("u0_strobe", {60'h0, ch_strobe0}, {60'h0, e0.strobe});
        check("u0_done_err_locked_slot", {59'h0, frame_done0, frame_err0, locked0, slot0},
              {59'h0, e0.done, e0.err, e0.locked, e0.slot});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (|ch_strobe1 || frame_done1 || frame_err1)) begin
      if (exp_q1.size() == 0) begin
        check("u1_unexpected_event", {59'h0, frame_done1, frame_err1, ch_strobe1}, 64'h0);
      end else begin
        e1 = exp_q1.pop_front();
        check("u1_ch_data", {16'h0, ch_data1}, e1.data);
        check("u1_strobe", {60'h0, 1'b0, ch_strobe1}, {60'h0, e1.strobe});
        check("u1_done_err_locked_slot", {59'h0, frame_done1, frame_err1, locked1, slot1},
              {59'h0, e1.done, e1.err, e1.locked, e1.slot});
      end
    end
  end

  initial begin
    clear_model(0);
    clear_model(1);
    rst_n = 1'b0;
    #12;
    check("reset_ch_data0", {32'h0, ch_data0}, 64'h0);
    check("reset_flags0", {57'h0, ch_strobe0, locked0, slot0}, 64'h0);
    check("reset_flags1", {58'h0, ch_strobe1, locked1, slot1}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean lock
    drive(0, 1, 0, 16'hAA);
    drive(0, 1, 0, 16'hBB);
    check("hunt_discard_locked", {63'h0, locked0}, 64'h0);
    drive(0, 1, 1, 16'h11);
    drive(0, 1, 0, 16'h22);
    drive(0, 1, 0, 16'h33);
    drive(0, 1, 0, 16'h44);
    check("clean_ch_data", {32'h0, ch_data0}, 64'h44332211);
    check("clean_locked", {63'h0, locked0}, 64'h1);

    // gapped valid with frame_sync wiggling while idle
    drive(0, 1, 1, 16'h11); gaps(0, 3);
    drive(0, 1, 0, 16'h22); gaps(0, 3);
    drive(0, 1, 0, 16'h33); gaps(0, 3);
    drive(0, 1, 0, 16'h44);
    check("gapped_ch_data", {32'h0, ch_data0}, 64'h44332211);

    // missing sync, then relock
    drive(0, 1, 0, 16'h55);
    check("missing_sync_locked", {63'h0, locked0}, 64'h0);
    check("missing_sync_ch0", {56'h0, ch_data0[7:0]}, 64'h11);
    drive(0, 1, 1, 16'h66);
    check("relock_ch0", {56'h0, ch_data0[7:0]}, 64'h66);
    drive(0, 1, 0, 16'h12);
    drive(0, 1, 0, 16'h13);
    drive(0, 1, 0, 16'h14);

    // short frame
    drive(0, 1, 1, 16'h01);
    drive(0, 1, 0, 16'h02);
    drive(0, 1, 1, 16'h0A);
    drive(0, 1, 0, 16'h0B);
    drive(0, 1, 0, 16'h0C);
    drive(0, 1, 0, 16'h0D);
    check("short_frame_ch_data", {32'h0, ch_data0}, 64'h0D0C0B0A);

    // reset mid-frame
    drive(0, 1, 1, 16'hC1);
    drive(0, 1, 0, 16'hC2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ch_data0", {32'h0, ch_data0}, 64'h0);
    check("midrst_flags0", {57'h0, ch_strobe0, frame_done0, frame_err0, locked0, slot0}, 64'h0);
    clear_model(0);
    clear_model(1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(0, 1, 0, 16'h99);
    check("post_rst_discard", {31'h0, locked0, ch_data0}, 64'h0);

    // NCH=3, W=16 back-to-back frames
    drive(1, 1, 1, 16'hAAAA);
    drive(1, 1, 0, 16'hBBBB);
    drive(1, 1, 0, 16'hCCCC);
    check("n3_wrap_slot", {62'h0, slot1}, 64'h0);
    drive(1, 1, 1, 16'h1111);
    drive(1, 1, 0, 16'h2222);
    drive(1, 1, 0, 16'h3333);
    check("n3_ch_data", {16'h0, ch_data1}, 64'h333322221111);

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            16'($urandom));
    end

    @(negedge clk);
    #1;
    check("u0_queue_drained", 64'(exp_q0.size()), 64'h0);
    check("u1_queue_drained", 64'(exp_q1.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive end of a time-division multiplexed word stream: one serial word lane carries NCH channels in fixed slot order, and slot 0 is marked by frame_sync.
- The block locks to the frame, steers each accepted word into that channel's holding register and pulses a per-channel strobe.
- It flags frame completion and framing errors.
- It sits downstream of the TDM mux/serializer and feeds per-channel consumers.

Parameters:
- NCH, 4, number of channels per frame (≥2).
- W, 8, data word width in bits.
- SW, $clog2(NCH), slot counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  W  incoming TDM word
- din_valid  input  1  din carries a word this cycle
- frame_sync  input  1  qualifies din as slot 0 (meaningful only with din_valid)
- ch_data  output  NCH*W  channel holding registers; channel k at bits [k*W +: W]
- ch_strobe  output  NCH  one-cycle pulse, bit k set when ch_data channel k was updated
- frame_done  output  1  one-cycle pulse when slot NCH-1 is written
- frame_err  output  1  one-cycle pulse on a framing violation
- locked  output  1  high while in LOCKED state
- slot  output  SW  next expected slot index (debug)

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=HUNT, slot=0, ch_data=0, ch_strobe=0, frame_done=0, frame_err=0, locked=0.
- All outputs are registered. Latency is 1 cycle: a word accepted at edge N appears on ch_data/ch_strobe after edge N.
- ch_strobe, frame_done and frame_err are single-cycle pulses, 0 by default each cycle.
- A cycle with din_valid=0 changes nothing, and frame_sync is ignored in that cycle.
- HUNT state:
  - din_valid & !frame_sync: word discarded, no error.
  - din_valid & frame_sync: write channel 0, strobe bit 0, slot←1, go LOCKED.
- LOCKED state, with din_valid=1:
  - slot=0 & frame_sync: normal frame start. Write ch0, slot←1.
  - slot=0 & !frame_sync: missing sync. frame_err=1, no write, slot←0, go HUNT (locked falls next cycle).
  - slot≠0 & !frame_sync: write channel slot, strobe that bit. If slot=NCH-1, frame_done=1 and slot wraps to 0; else slot←slot+1.
  - slot≠0 & frame_sync: short frame. frame_err=1, the word is treated as slot 0 (write ch0, strobe bit 0), slot←1, stay LOCKED. frame_done is not asserted.
- Channels not written keep their previous value; ch_data is never cleared except by reset.
- At most one ch_strobe bit is high per cycle. frame_done and frame_err are never high together.
- Reset mid-frame: everything returns to reset values immediately. The next frame must present frame_sync to relock.
- Slot arithmetic is modulo NCH. When NCH is not a power of two, the wrap is explicit at NCH-1 and never relies on counter overflow.

Decomposition:
- Package tdm_pkg holds:
  - state typedef {HUNT, LOCKED};
  - default constants TDM_NCH=4 and TDM_W=8.
- One natural sub-module, tdm_slot_counter: a SW-bit counter with load-to-1, clear and wrap-at-NCH-1. It outputs slot and a last_slot flag.
- Channel steering (slot decode to write enable) stays inline as a decoder in the top.

Test Plan:
- Clean lock: 2 unsynced words (0xAA, 0xBB), then sync frame 0x11,0x22,0x33,0x44 → first 2 discarded with no err; ch_data=0x44332211 after the last word; strobes 0001,0010,0100,1000 on consecutive cycles; frame_done with the last; locked=1.
- Gapped valid: same frame with din_valid low 3 cycles between words and frame_sync toggled during the gaps → identical result; no err.
- Missing sync: after a locked frame, send 0x55 with no frame_sync at slot 0 → frame_err=1, ch0 unchanged (0x11), locked=0 next cycle. Then sync 0x66 → relock, ch0=0x66.
- Short frame: sync 0x01, 0x02, then sync 0x0A,0x0B,0x0C,0x0D → frame_err pulse on 0x0A, no frame_done for the first frame; final ch_data=0x0D0C0B0A; one frame_done.
- Reset mid-frame: assert rst_n low after slot 1 of a frame → all outputs 0 within the same cycle (async). After release, a non-sync word is discarded.
- Parameter sweep NCH=3, W=16: 2 back-to-back frames → slot wraps 2→0; frame_done every 3rd accepted word; no err.
